// File: rtl/nexys_hls4ml_div_22s_9s_13u_seq_if.sv
// Operand/result handshake bundle for the 22s/9s -> 13u divider.
// master drives operands and accepts results; slave is the divider.
interface nexys_hls4ml_div_22s_9s_13u_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] din0;
  logic [8:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] dout;
  logic [8:0]  rem;
  logic        err;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, err
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, err
  );
endinterface

// File: rtl/nexys_hls4ml_div_22s_9s_13u_seq.sv
// Sequential radix-2 restoring divider recovering the 13u operand
// of a 13u x 9s -> 22s product; saturating, flags bad quotients.
module nexys_hls4ml_div_22s_9s_13u_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 22,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 13
) (
  input logic clk,
  input logic reset,
  input logic ce,
  nexys_hls4ml_div_22s_9s_13u_seq_if.slave bus
);
  localparam int AW = din0_WIDTH;
  localparam int BW = din1_WIDTH;
  localparam int QW = dout_WIDTH;

  if (AW != 22 || BW != 9 || QW != 13 || ID < 0) begin : g_bad_cfg
    $error("unsupported divider configuration");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] a_q, a_n;
  logic [AW-1:0] q_q, q_n;
  logic [BW-1:0] b_q, b_n;
  logic [BW-1:0] r_q, r_n;
  logic [4:0]    cnt_q, cnt_n;
  logic          negq_q, negq_n;
  logic          sgn_q, sgn_n;
  logic          div0_q, div0_n;
  logic [QW-1:0] dout_q, dout_n;
  logic [BW-1:0] rem_q, rem_n;
  logic          err_q, err_n;

  logic [BW:0]   r_sh;
  logic [BW-1:0] r_sub;
  logic          ge;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.dout      = dout_q;
  assign bus.rem       = rem_q;
  assign bus.err       = err_q;

  // Next state, one restoring step, and result fixup
  always_comb begin
    state_n = state;
    a_n     = a_q;
    q_n     = q_q;
    b_n     = b_q;
    r_n     = r_q;
    cnt_n   = cnt_q;
    negq_n  = negq_q;
    sgn_n   = sgn_q;
    div0_n  = div0_q;
    dout_n  = dout_q;
    rem_n   = rem_q;
    err_n   = err_q;
    r_sh    = {r_q, a_q[AW-1]};
    ge      = (r_sh >= {1'b0, b_q});
    r_sub   = r_sh[BW-1:0] - b_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_n    = bus.din0[AW-1] ? (~bus.din0 + 1'b1)
                                  : bus.din0;
          b_n    = bus.din1[BW-1] ? (~bus.din1 + 1'b1)
                                  : bus.din1;
          negq_n = bus.din0[AW-1] ^ bus.din1[BW-1];
          sgn_n  = bus.din0[AW-1];
          div0_n = (bus.din1 == '0);
          q_n    = '0;
          r_n    = '0;
          cnt_n  = 5'd21;
          state_n = div0_n ? FIXUP : CALC;
        end
      end
      CALC: begin
        a_n   = {a_q[AW-2:0], 1'b0};
        q_n   = {q_q[AW-2:0], ge};
        r_n   = ge ? r_sub : r_sh[BW-1:0];
        cnt_n = cnt_q - 5'd1;
        if (cnt_q == 5'd0)
          state_n = FIXUP;
      end
      FIXUP: begin
        state_n = DONE;
        if (div0_q) begin
          dout_n = '1;
          rem_n  = '0;
          err_n  = 1'b1;
        end else begin
          rem_n = sgn_q ? (~r_q + 1'b1) : r_q;
          if (negq_q && q_q != '0) begin
            dout_n = '0;
            err_n  = 1'b1;
          end else if (|q_q[AW-1:QW]) begin
            dout_n = '1;
            err_n  = 1'b1;
          end else begin
            dout_n = q_q[QW-1:0];
            err_n  = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers, frozen while ce is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      q_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      sgn_q  <= 1'b0;
      div0_q <= 1'b0;
      dout_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      a_q    <= a_n;
      q_q    <= q_n;
      b_q    <= b_n;
      r_q    <= r_n;
      cnt_q  <= cnt_n;
      negq_q <= negq_n;
      sgn_q  <= sgn_n;
      div0_q <= div0_n;
      dout_q <= dout_n;
      rem_q  <= rem_n;
      err_q  <= err_n;
    end
  end
endmodule
